// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the LCD controller receive path (nibble packer).
// Holds nibble/word geometry, the packer state encoding and a nibble-insert helper.
package lcd_ctrl_pkg;

  localparam int NIB_W   = 4;
  localparam int NUM_NIB = 8;
  localparam int WORD_W  = NIB_W * NUM_NIB;
  localparam int IDX_W   = 3;

  typedef enum logic {
    PK_FILL = 1'b0,
    PK_HOLD = 1'b1
  } pk_state_e;

  // Returns 'word' with nibble slot 'idx' replaced by 'nib'.
  function automatic logic [WORD_W-1:0] put_nib(
    input logic [WORD_W-1:0] word,
    input logic [IDX_W-1:0]  idx,
    input logic [NIB_W-1:0]  nib
  );
    logic [WORD_W-1:0] w;
    w = word;
    w[idx*NIB_W +: NIB_W] = nib;
    return w;
  endfunction

endpackage

// File: rtl/nibble_packer_8.sv
// Packs 4-bit nibbles (nibble 0 first) into 32-bit words with valid/ready on both sides.
// Optional partial-word flush is built when NIBBLE_PACKER_FLUSH_EN is defined.
module nibble_packer_8
  import lcd_ctrl_pkg::*;
#(
  parameter int NUM_NIB = 8,
  parameter int NIB_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NIB_W-1:0]         nib_in,
  input  logic                     nib_valid,
  output logic                     nib_ready,
  input  logic                     flush,
  output logic [IDX_W-1:0]         sel,
  output logic [NUM_NIB*NIB_W-1:0] word_out,
  output logic [IDX_W:0]           word_cnt,
  output logic                     word_valid,
  input  logic                     word_ready,
  output pk_state_e                dbg_state
);

  // Handshake rule on both sides: a transfer happens on a rising clk edge where
  // valid and ready are both high; valid must hold with stable data until then,
  // and ready may depend combinationally on en and state but never on valid.

  localparam int W = NUM_NIB * NIB_W;

  pk_state_e        r_state;
  pk_state_e        w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [W-1:0]     r_word;
  logic [W-1:0]     w_word_nxt;
  logic [IDX_W:0]   r_cnt;
  logic [IDX_W:0]   w_cnt_nxt;

  logic             w_accept;
  logic             w_last_nib;
  logic             w_flush_go;

  assign nib_ready  = ~rst & en & (r_state == PK_FILL);
  assign w_accept   = nib_valid & nib_ready;
  assign w_last_nib = (r_idx == IDX_W'(NUM_NIB - 1));

`ifdef NIBBLE_PACKER_FLUSH_EN
  logic [IDX_W:0] w_cnt_flush;

  // A flush only closes a word that holds at least one nibble, counting one
  // accepted in the same cycle.
  assign w_flush_go  = en & flush & ((r_idx != '0) | w_accept);
  assign w_cnt_flush = {1'b0, r_idx} + {{IDX_W{1'b0}}, w_accept};
`else
  logic w_unused_flush;

  assign w_flush_go     = 1'b0;
  assign w_unused_flush = flush;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_word_nxt  = r_word;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      PK_FILL: begin
        if (w_accept) begin
          w_word_nxt = put_nib(r_word, r_idx, nib_in);
          w_idx_nxt  = r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
        end
        if (w_accept && w_last_nib) begin
          w_state_nxt = PK_HOLD;
          w_idx_nxt   = '0;
          w_cnt_nxt   = (IDX_W+1)'(NUM_NIB);
        end else if (w_flush_go) begin
          w_state_nxt = PK_HOLD;
          w_idx_nxt   = '0;
`ifdef NIBBLE_PACKER_FLUSH_EN
          w_cnt_nxt   = w_cnt_flush;
`endif
        end
      end
      PK_HOLD: begin
        // Consumption clears the word so unfilled slots of the next one read 0.
        if (word_ready) begin
          w_state_nxt = PK_FILL;
          w_idx_nxt   = '0;
          w_word_nxt  = '0;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = PK_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PK_FILL;
      r_idx   <= '0;
      r_word  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_word  <= w_word_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign sel        = (r_state == PK_FILL) ? r_idx : '0;
  assign word_out   = r_word;
  assign word_cnt   = r_cnt;
  assign word_valid = (r_state == PK_HOLD);
  assign dbg_state  = r_state;

endmodule
